// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl
// Shift-register controller for an SPI mode-0 master. It produces SCLK and
// a one-cycle launch strobe for the downstream MOSI serializer, and shifts
// MISO into the same register that holds the outgoing word.
//
// Build option: define SPI_SHIFT_RX_EN to enable the receive path. Without
// it, zeros are shifted in instead of MISO, rx_data stays 0 and the timing
// is identical.

module spi_shift_ctrl #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 go,
    input  logic                 lsb,
    input  logic [2:0]           char_len,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [7:0]           tx_data,
    input  logic                 miso_pad_i,
    output logic [7:0]           trx,
    output logic                 transfer_en,
    output logic                 sclk_pad_o,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rx_data
);

    // LAUNCH strobes the serializer, LOW and HIGH are the two SCLK phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        LOW    = 2'd2,
        HIGH   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    // Settings captured when a transfer is accepted
    logic                   r_lsb;
    logic [3:0]             r_bitLen;
    logic [DIV_WIDTH-1:0]   r_divider;

    // Transfer progress
    logic [DIV_WIDTH-1:0]   r_divCnt;
    logic [3:0]             r_bitCnt;
    logic [7:0]             r_trx;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_divDone;
    logic                   w_lowExit;
    logic                   w_highExit;
    logic                   w_misoBit;
    logic [3:0]             w_charLenN;
    logic [DIV_WIDTH-1:0]   w_divCntInc;
    logic [7:0]             w_mask;
    logic [7:0]             w_shiftUp;
    logic [7:0]             w_shiftDn;
    logic [7:0]             w_shifted;

    // A char_len of 0 stands for a full 8-bit word
    assign w_charLenN  = (char_len == 3'd0) ? 4'd8 : {1'b0, char_len};

    // A new transfer can only start from IDLE; go while busy is dropped
    assign w_accept    = (r_state == IDLE) && go;

    // Each SCLK phase lasts divider+1 cycles, counted from 0 up to divider
    assign w_divDone   = (r_divCnt == r_divider);
    assign w_lowExit   = (r_state == LOW)  && w_divDone;
    assign w_highExit  = (r_state == HIGH) && w_divDone;
    assign w_divCntInc = r_divCnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};

`ifdef SPI_SHIFT_RX_EN
    assign w_misoBit = miso_pad_i;
`else
    logic w_unusedMiso;
    assign w_unusedMiso = miso_pad_i;
    assign w_misoBit    = 1'b0;
`endif

    // Active-bit mask: bits below the captured word length take part in the shift
    always_comb begin
        w_mask = 8'h00;
        for (int k = 0; k < 8; k++) begin
            w_mask[k] = (4'(k) < r_bitLen);
        end
    end

    // Both shift directions are built as plain vectors so no index leaves 0..7
    assign w_shiftUp = {r_trx[6:0], w_misoBit};
    assign w_shiftDn = {1'b0, r_trx[7:1]};

    // Sample-edge shift: MSB-first enters at bit 0, LSB-first enters at bit N-1
    always_comb begin
        w_shifted = r_trx;
        for (int k = 0; k < 8; k++) begin
            if (w_mask[k]) begin
                if (r_lsb) begin
                    w_shifted[k] = (4'(k) == (r_bitLen - 4'd1)) ? w_misoBit : w_shiftDn[k];
                end else begin
                    w_shifted[k] = w_shiftUp[k];
                end
            end
        end
    end

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one launch cycle, then a low and a high phase per bit
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                w_nextState = LOW;
            end
            LOW: begin
                if (w_divDone) begin
                    w_nextState = HIGH;
                end
            end
            HIGH: begin
                if (w_divDone) begin
                    w_nextState = (r_bitCnt != 4'd0) ? LAUNCH : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs decoded straight from the state so reset clears them at once
    always_comb begin
        transfer_en = 1'b0;
        sclk_pad_o  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            LAUNCH: begin
                transfer_en = 1'b1;
                busy        = 1'b1;
            end
            LOW: begin
                busy        = 1'b1;
            end
            HIGH: begin
                sclk_pad_o  = 1'b1;
                busy        = 1'b1;
            end
            default: begin
                transfer_en = 1'b0;
            end
        endcase
    end

    // Capture transfer settings only on an accepted go, so later input changes are ignored
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_lsb     <= 1'b0;
            r_bitLen  <= 4'd0;
            r_divider <= '0;
        end else if (w_accept) begin
            r_lsb     <= lsb;
            r_bitLen  <= w_charLenN;
            r_divider <= divider;
        end
    end

    // Phase counter restarts on every state change, so it never has to wrap on its own
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_divCnt <= '0;
        end else if (w_nextState != r_state) begin
            r_divCnt <= '0;
        end else if ((r_state == LOW) || (r_state == HIGH)) begin
            r_divCnt <= w_divCntInc;
        end
    end

    // Remaining-bit counter: loaded with N on accept, decremented on each sample
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_bitCnt <= 4'd0;
        end else if (w_accept) begin
            r_bitCnt <= w_charLenN;
        end else if (w_lowExit) begin
            r_bitCnt <= r_bitCnt - 4'd1;
        end
    end

    // Shift register: loaded with the transmit word, shifted on each rising SCLK
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_trx <= 8'h00;
        end else if (w_accept) begin
            r_trx <= tx_data;
        end else if (w_lowExit) begin
            r_trx <= w_shifted;
        end
    end

    // Completion pulse on the final falling SCLK edge
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_highExit && (r_bitCnt == 4'd0);
        end
    end

`ifdef SPI_SHIFT_RX_EN
    logic [7:0] r_rxData;

    // Received word is published at completion with the unused upper bits cleared
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rxData <= 8'h00;
        end else if (w_highExit && (r_bitCnt == 4'd0)) begin
            r_rxData <= r_trx & w_mask;
        end
    end

    assign rx_data = r_rxData;
`else
    assign rx_data = 8'h00;
`endif

    assign trx  = r_trx;
    assign done = r_done;

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb_spi_shift_ctrl
// Scoreboard bench for spi_shift_ctrl. Each transfer pushes its expected
// launch pulses, SCLK rises and completion into a queue; a monitor pops and
// compares whenever the DUT shows one of those events.

module tb_spi_shift_ctrl;

    localparam int EV_PULSE = 0;
    localparam int EV_RISE  = 1;
    localparam int EV_DONE  = 2;

`ifdef SPI_SHIFT_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic       pclk;
    logic       presetn;
    logic       go;
    logic       lsb;
    logic [2:0] charLen;
    logic [7:0] divider;
    logic [7:0] txData;
    logic       misoPadI;
    logic [7:0] trx;
    logic       transferEn;
    logic       sclkPadO;
    logic       busy;
    logic       done;
    logic [7:0] rxData;

    typedef struct {
        int         kind;
        int         cyc;
        int         bitIdx;
        logic [7:0] val;
    } ev_t;

    ev_t        sb[$];
    int         cycleCnt = 0;
    int         nChecks  = 0;
    int         nBad     = 0;
    logic [7:0] misoSeq  = 8'h00;
    int         misoIdx  = 8;
    logic       prevSclk = 1'b0;
    int         gStart;

    spi_shift_ctrl #(
        .DIV_WIDTH (8)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .go          (go),
        .lsb         (lsb),
        .char_len    (charLen),
        .divider     (divider),
        .tx_data     (txData),
        .miso_pad_i  (misoPadI),
        .trx         (trx),
        .transfer_en (transferEn),
        .sclk_pad_o  (sclkPadO),
        .busy        (busy),
        .done        (done),
        .rx_data     (rxData)
    );

    // Free-running clock
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Cycle index used as the time base for all expectations
    always @(posedge pclk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Direct comparison of a sampled value against a hand-computed constant
    task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the next expected event and compare kind, cycle and value
    task automatic checkOutput(input int kind, input string name);
        ev_t        e;
        logic [7:0] act;
        nChecks++;
        if (sb.size() == 0) begin
            nBad++;
            $display("[TB] FAIL %s: unexpected event at cycle %0d", name, cycleCnt);
            return;
        end
        e = sb.pop_front();
        if (kind == EV_DONE) begin
            act = rxData;
        end else if (kind == EV_PULSE) begin
            act = {7'd0, trx[e.bitIdx]};
        end else begin
            act = {7'd0, busy};
        end
        if ((e.kind != kind) || (e.cyc != cycleCnt) || (act !== e.val)) begin
            nBad++;
            $display("[TB] FAIL %s: got kind=%0d cycle=%0d value=%h expected kind=%0d cycle=%0d value=%h",
                     name, kind, cycleCnt, act, e.kind, e.cyc, e.val);
        end
    endtask

    // Monitor: every launch pulse, SCLK rise and done pulse is checked against the queue
    initial begin
        forever begin
            @(negedge pclk);
            if (presetn) begin
                if (transferEn) checkOutput(EV_PULSE, "launchPulse");
                if (sclkPadO && !prevSclk) checkOutput(EV_RISE, "sclkRise");
                if (done) checkOutput(EV_DONE, "donePulse");
            end
            prevSclk = sclkPadO;
        end
    end

    // MISO driver: presents the next receive bit after each launch pulse
    initial begin
        forever begin
            @(negedge pclk);
            if (presetn && transferEn && (misoIdx < 8)) begin
                misoPadI = misoSeq[misoIdx];
                misoIdx++;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        repeat (20000) @(posedge pclk);
        $display("[TB] FAIL watchdog: cycle %0d reached, expected finish before 20000", cycleCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one transfer (go for one cycle) and queue its expected events
    task automatic applyStimulus(input logic [7:0] tx, input logic [2:0] len, input logic l,
                                 input logic [7:0] div, input logic [7:0] mSeq,
                                 input logic [7:0] expBits, input logic [7:0] expRx);
        int  n;
        int  p;
        int  g;
        ev_t e;
        n = (len == 3'd0) ? 8 : int'(len);
        p = 2 * (int'(div) + 1) + 1;
        g = cycleCnt;
        for (int i = 0; i < n; i++) begin
            e.kind   = EV_PULSE;
            e.cyc    = g + 1 + i * p;
            e.bitIdx = l ? 0 : n - 1;
            e.val    = {7'd0, expBits[i]};
            sb.push_back(e);
            e.kind   = EV_RISE;
            e.cyc    = g + 1 + i * p + 1 + (int'(div) + 1);
            e.bitIdx = 0;
            e.val    = 8'h01;
            sb.push_back(e);
        end
        e.kind   = EV_DONE;
        e.cyc    = g + 1 + n * p;
        e.bitIdx = 0;
        e.val    = RX_EN ? expRx : 8'h00;
        sb.push_back(e);
        misoSeq = mSeq;
        misoIdx = 0;
        txData  = tx;
        charLen = len;
        lsb     = l;
        divider = div;
        go      = 1'b1;
        @(posedge pclk);
        #1;
        go      = 1'b0;
        txData  = ~tx;
        charLen = len + 3'd3;
        lsb     = ~l;
        divider = div ^ 8'h0F;
    endtask

    // A go pulse with unrelated settings that must be ignored while busy
    task automatic pokeGo();
        go      = 1'b1;
        txData  = 8'h55;
        charLen = 3'd7;
        lsb     = 1'b1;
        divider = 8'd0;
        @(posedge pclk);
        #1;
        go      = 1'b0;
    endtask

    task automatic waitUntil(input int c);
        while (cycleCnt < c) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Wait for all queued events with a cycle budget; leftovers count as a failure
    task automatic waitIdle(input int budget, input string name);
        int b;
        b = budget;
        while ((sb.size() != 0) && (b > 0)) begin
            @(posedge pclk);
            #1;
            b--;
        end
        nChecks++;
        if (sb.size() != 0) begin
            nBad++;
            $display("[TB] FAIL %s: %0d events still pending, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(posedge pclk);
        #1;
    endtask

    initial begin
        presetn  = 1'b0;
        go       = 1'b0;
        lsb      = 1'b0;
        charLen  = 3'd0;
        divider  = 8'd0;
        txData   = 8'h00;
        misoPadI = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        checkValue("resetTrx",    trx, 8'h00);
        checkValue("resetCtl",    {4'd0, transferEn, sclkPadO, busy, done}, 8'h00);
        checkValue("resetRxData", rxData, 8'h00);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        $display("[TB] reset released at cycle %0d", cycleCnt);

        // A5, 8 bits MSB-first, fastest clock
        applyStimulus(8'hA5, 3'd0, 1'b0, 8'd0, 8'h3C, 8'hA5, 8'h3C);
        waitIdle(100, "xferA5");

        // 0B, 4 bits LSB-first
        applyStimulus(8'h0B, 3'd4, 1'b1, 8'd0, 8'h06, 8'h0B, 8'h06);
        waitIdle(100, "xfer0B");

        // Ignored go mid-transfer, then a go in the done cycle chains the next transfer
        gStart = cycleCnt;
        applyStimulus(8'h3C, 3'd2, 1'b0, 8'd1, 8'h03, 8'h00, 8'h03);
        waitUntil(gStart + 5);
        pokeGo();
        waitUntil(gStart + 11);
        checkValue("doneCycleReached", {7'd0, done}, 8'h01);
        applyStimulus(8'h01, 3'd1, 1'b0, 8'd3, 8'h01, 8'h01, 8'h01);
        waitIdle(100, "xferChain");

        // Maximum divider, 1 bit LSB-first; stale upper bits must be masked off rx_data
        applyStimulus(8'hFE, 3'd1, 1'b1, 8'hFF, 8'h01, 8'h00, 8'h01);
        waitIdle(700, "xferMaxDiv");

        // Reset in the middle of a transfer
        gStart = cycleCnt;
        applyStimulus(8'hFF, 3'd0, 1'b0, 8'd0, 8'hFF, 8'hFF, 8'hFF);
        waitUntil(gStart + 7);
        #2;
        presetn = 1'b0;
        #1;
        checkValue("midResetTrx",    trx, 8'h00);
        checkValue("midResetCtl",    {4'd0, transferEn, sclkPadO, busy, done}, 8'h00);
        checkValue("midResetRxData", rxData, 8'h00);
        sb.delete();
        repeat (3) @(posedge pclk);
        #1;
        presetn = 1'b1;
        repeat (30) @(posedge pclk);
        #1;
        checkValue("idleAfterReset", {7'd0, busy}, 8'h00);

        // First go after reset is accepted normally: 96, 3 bits MSB-first
        applyStimulus(8'h96, 3'd3, 1'b0, 8'd0, 8'h05, 8'h03, 8'h05);
        waitIdle(100, "xferAfterReset");

        checkValue("scoreboardEmpty", 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/spi_shift_ctrl.md
SPI_SHIFT_CTRL -- requirements
Module: spi_shift_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of the divider input.
REQ-002 pclk  input  1  single clock; all state on rising edge.
REQ-003 presetn  input  1  reset, asynchronous assert, active-low.
REQ-004 go  input  1  single-cycle transfer start request.
REQ-005 lsb  input  1  1 = LSB-first, 0 = MSB-first.
REQ-006 char_len  input  3  bit count N; 0 encodes 8, 1..7 encode 1..7.
REQ-007 divider  input  DIV_WIDTH  SCLK half-period is divider+1 pclk cycles.
REQ-008 tx_data  input  8  word to transmit, sampled on accepted go.
REQ-009 miso_pad_i  input  1  serial receive data.
REQ-010 trx  output  8  shift register; feeds the downstream MOSI serializer.
REQ-011 transfer_en  output  1  one-cycle launch pulse; the serializer registers the current bit on it.
REQ-012 sclk_pad_o  output  1  serial clock, mode 0 (idle low).
REQ-013 busy  output  1  transfer in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 rx_data  output  8  received word, bits [7:N] zero.

Function
REQ-016 FSM states: IDLE, LAUNCH, LOW, HIGH; busy=1 in every state except IDLE.
REQ-017 IDLE with go=1: latch lsb, char_len, divider; load trx<=tx_data; bit_cnt<=N; go to LAUNCH next cycle.
REQ-018 go while busy=1 is ignored, and latched settings are unaffected.
REQ-019 LAUNCH lasts exactly one cycle, drives transfer_en=1 and sclk_pad_o=0, then goes to LOW.
REQ-020 transfer_en is 0 in every other state.
REQ-021 LOW holds sclk_pad_o=0 for divider+1 cycles; on exit, sclk_pad_o rises, miso_pad_i is sampled, and the FSM goes to HIGH.
REQ-022 Sample shift with MSB-first: trx[0]<=miso, trx[k]<=trx[k-1] for 1<=k<=N-1, bits >=N hold.
REQ-023 Sample shift with LSB-first: trx[N-1]<=miso, trx[k]<=trx[k+1] for 0<=k<N-1, bits >=N hold.
REQ-024 bit_cnt decrements on each sample.
REQ-025 HIGH holds sclk_pad_o=1 for divider+1 cycles; on exit, sclk_pad_o falls.
REQ-026 On HIGH exit with bit_cnt!=0, next state is LAUNCH; with bit_cnt==0, next state is IDLE, done=1 for one cycle, and rx_data<=trx with bits [7:N] cleared.
REQ-027 Latency: done is high exactly 1+N*(2*(divider+1)+1) cycles after the go cycle.
REQ-028 The divider counter wraps only via state change; divider=max value is legal, giving a half-period of 2^DIV_WIDTH cycles.
REQ-029 Changes to divider, char_len, lsb or tx_data during busy have no effect.
REQ-030 go in the same cycle done is high is accepted, because the FSM is already in IDLE.

Reset
REQ-031 presetn low forces state=IDLE, trx=0, bit_cnt=0, sclk_pad_o=0, transfer_en=0, busy=0, done=0, rx_data=0, asynchronously.
REQ-032 Reset mid-transfer aborts the transfer with no done pulse; rx_data is cleared.
REQ-033 After presetn deasserts, the first go is accepted normally.

Configuration
REQ-034 With macro SPI_SHIFT_RX_EN defined: the receive path operates as in REQ-021 to REQ-026.
REQ-035 With SPI_SHIFT_RX_EN undefined: 0 is shifted in place of miso, rx_data is held at 0, miso_pad_i is unused, and all timing is unchanged.

Verification
REQ-036 tx_data=A5, char_len=0, lsb=0, divider=0, miso bits 0,0,1,1,1,1,0,0 -> transfer_en pulses at cycles 1,4,...,22; trx[7] at the pulses is 1,0,1,0,0,1,0,1; done at cycle 25; rx_data=3C.
REQ-037 tx_data=0B, char_len=4, lsb=1, divider=0, miso LSB-first 0,1,1,0 -> trx[0] at pulses is 1,1,0,1; done at cycle 13; rx_data=06.
REQ-038 divider=3, char_len=1 -> sclk low 4 / high 4 cycles; done at cycle 10.
REQ-039 go asserted at cycle 5 of a transfer -> ignored, done timing unchanged; go in the done cycle -> new transfer starts next cycle.
REQ-040 presetn low at cycle 7 -> all outputs zero immediately, no done; macro off with REQ-036 stimulus -> rx_data=00, identical sclk/transfer_en timing.
